// File: rtl/wishbone_regfile_slave_if.sv
// Wishbone classic bus bundle between wishbone_master and wishbone_regfile_slave.
interface wishbone_regfile_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output cyc_i, stb_i, we_i, addr_i, data_i,
    input  data_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, data_i,
    output data_o, ack_o, err_o
  );
endinterface

// File: rtl/wishbone_regfile_slave.sv
// Wishbone classic register-file slave with programmable wait states and registered ack.
// Define WB_REGFILE_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wishbone_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  wishbone_regfile_slave_if.slave       wb,
  output logic [31:0]                   reg0_o
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_regs [DEPTH];
  logic [31:0] r_data;
  logic        r_ack;
`ifdef WB_REGFILE_ERR_EN
  logic        r_err;
`endif

  logic          w_req;
  logic          w_fire;
  logic          w_act_we;
  logic [31:0]   w_act_addr;
  logic [31:0]   w_act_data;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  assign w_req = wb.cyc_i & wb.stb_i;

  // With zero wait states the access completes on the capture edge, so live bus values are used.
  always_comb begin
    w_act_we   = r_we;
    w_act_addr = r_addr;
    w_act_data = r_wdata;
    w_fire     = 1'b0;
    if (r_state == S_IDLE) begin
      w_act_we   = wb.we_i;
      w_act_addr = wb.addr_i;
      w_act_data = wb.data_i;
      w_fire     = w_req && (WAIT_STATES == 0);
    end else if (r_state == S_WAIT) begin
      w_fire     = w_req && (r_cnt == 4'd0);
    end
    w_in_range = ({1'b0, w_act_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_act_addr} < LIMIT);
    w_idx      = w_act_addr[AW+1:2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_ack   <= 1'b0;
`ifdef WB_REGFILE_ERR_EN
      r_err   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= 32'd0;
    end else begin
      r_ack <= 1'b0;
`ifdef WB_REGFILE_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= wb.we_i;
            r_addr  <= wb.addr_i;
            r_wdata <= wb.data_i;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (!w_req)              r_state <= S_IDLE;
          else if (r_cnt == 4'd0)  r_state <= S_RESP;
          else                     r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_HOLD;
        S_HOLD:  if (!w_req) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Termination and data movement happen on the edge that enters RESP.
      if (w_fire) begin
        if (w_in_range) begin
          r_ack <= 1'b1;
          if (w_act_we) r_regs[w_idx] <= w_act_data;
          else          r_data        <= r_regs[w_idx];
        end else begin
`ifdef WB_REGFILE_ERR_EN
          r_err <= 1'b1;
`else
          r_ack <= 1'b1;
          if (!w_act_we) r_data <= 32'd0;
`endif
        end
      end
    end
  end

  assign wb.data_o = r_data;
  assign wb.ack_o  = r_ack;
`ifdef WB_REGFILE_ERR_EN
  assign wb.err_o  = r_err;
`else
  assign wb.err_o  = 1'b0;
`endif
  assign reg0_o    = r_regs[0];

endmodule

// File: tb/tb_wishbone_regfile_slave.sv
// Directed scoreboard bench for wishbone_regfile_slave with WAIT_STATES of 1, 3 and 0.
module tb_wishbone_regfile_slave;

`ifdef WB_REGFILE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        ack  [3];
  logic        err  [3];
  logic [31:0] reg0 [3];

  wishbone_regfile_slave_if wb0 ();
  wishbone_regfile_slave_if wb1 ();
  wishbone_regfile_slave_if wb2 ();

  assign wb0.cyc_i = cyc[0]; assign wb0.stb_i = stb[0]; assign wb0.we_i = we[0];
  assign wb0.addr_i = addr[0]; assign wb0.data_i = din[0];
  assign dout[0] = wb0.data_o; assign ack[0] = wb0.ack_o; assign err[0] = wb0.err_o;
  assign wb1.cyc_i = cyc[1]; assign wb1.stb_i = stb[1]; assign wb1.we_i = we[1];
  assign wb1.addr_i = addr[1]; assign wb1.data_i = din[1];
  assign dout[1] = wb1.data_o; assign ack[1] = wb1.ack_o; assign err[1] = wb1.err_o;
  assign wb2.cyc_i = cyc[2]; assign wb2.stb_i = stb[2]; assign wb2.we_i = we[2];
  assign wb2.addr_i = addr[2]; assign wb2.data_i = din[2];
  assign dout[2] = wb2.data_o; assign ack[2] = wb2.ack_o; assign err[2] = wb2.err_o;

  wishbone_regfile_slave #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .wb(wb0), .reg0_o(reg0[0]));
  wishbone_regfile_slave #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .wb(wb1), .reg0_o(reg0[1]));
  wishbone_regfile_slave #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .wb(wb2), .reg0_o(reg0[2]));

  typedef struct {
    int          k;
    logic        exp_err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  int          ws [3] = '{1, 3, 0};
  logic [31:0] mdl [3][16];
  logic [31:0] last_rd [3];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = 32'd0;
      for (int i = 0; i < 16; i++) mdl[k][i] = 32'd0;
    end
  endtask

  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input int hold);
    exp_t e;
    bit   inr;
    int   idx;
    int   lat;
    int   extra;
    inr = (a < 32'h40);
    idx = int'(a[5:2]);
    e.k = k;
    e.lat = 1 + ws[k];
    e.exp_err = !inr && ERR_EN;
    if (w) begin
      if (inr) mdl[k][idx] = d;
      e.data = last_rd[k];
    end else begin
      if (e.exp_err) e.data = last_rd[k];
      else           e.data = inr ? mdl[k][idx] : 32'd0;
      last_rd[k] = e.data;
    end
    sb.push_back(e);

    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; din[k] = d;
    @(posedge clk); #1;
    // Bus contents after capture must not matter.
    addr[k] = $urandom; din[k] = $urandom; we[k] = ~w;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        lat = i;
        break;
      end
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("ack", {31'd0, ack[e.k]}, {31'd0, !e.exp_err});
    check("err", {31'd0, err[e.k]}, {31'd0, e.exp_err});
    check("data_o", dout[e.k], e.data);
    check("reg0_o", reg0[e.k], mdl[e.k][0]);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) extra++;
      check("hold_data_o", dout[k], e.data);
    end
    if (hold > 0) check("held_strobe_extra_ack", 32'(extra), 32'd0);
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(negedge clk);
    check("single_pulse", {31'd0, ack[k] | err[k]}, 32'd0);
  endtask

  initial begin
    int acks;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; din[k] = 32'd0;
    end
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", {31'd0, ack[k]}, 32'd0);
      check("rst_err", {31'd0, err[k]}, 32'd0);
      check("rst_data_o", dout[k], 32'd0);
      check("rst_reg0_o", reg0[k], 32'd0);
    end

    // Populate, then reset in the middle of a WAIT cycle.
    txn(0, 1'b1, 32'h00, 32'h11, 0);
    txn(0, 1'b1, 32'h0C, 32'h22, 0);
    txn(0, 1'b0, 32'h0C, 32'h0, 0);
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0C; din[0] = 32'hA5;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    clear_model();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack[0] || err[0]) acks++;
    end
    check("midwait_rst_ack", 32'(acks), 32'd0);
    check("midwait_rst_data_o", dout[0], 32'd0);
    check("midwait_rst_reg0_o", reg0[0], 32'd0);
    txn(0, 1'b0, 32'h0C, 32'h0, 0);
    txn(0, 1'b0, 32'h00, 32'h0, 0);

    // Write/read with one wait state, held strobe, data_o stability.
    txn(0, 1'b1, 32'h0C, 32'hA5, 0);
    txn(0, 1'b0, 32'h0C, 32'h0, 10);
    txn(0, 1'b1, 32'h08, 32'h5A, 0);
    txn(0, 1'b0, 32'h0C, 32'h0, 0);
    txn(0, 1'b0, 32'h08, 32'h0, 0);

    // Out of range at BASE_ADDR + DEPTH*4.
    txn(0, 1'b1, 32'h40, 32'hFF, 0);
    txn(0, 1'b0, 32'h40, 32'h0, 0);
    txn(0, 1'b0, 32'h0C, 32'h0, 0);
    txn(0, 1'b0, 32'h3C, 32'h0, 0);
    txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);

    // Abort during WAIT with three wait states.
    txn(1, 1'b1, 32'h04, 32'h77, 0);
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h04; din[1] = 32'h99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[1] || err[1]) acks++;
    end
    check("abort_no_term", 32'(acks), 32'd0);
    cyc[1] = 1'b0;
    txn(1, 1'b0, 32'h04, 32'h0, 0);

    // Zero wait states: reg0_o follows the write edge.
    txn(2, 1'b1, 32'h00, 32'h3C, 0);
    txn(2, 1'b0, 32'h00, 32'h0, 3);
    txn(2, 1'b1, 32'h3C, 32'hC3, 0);
    txn(2, 1'b0, 32'h3C, 32'h0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
